// File: rtl/sram_axil_responder.sv
// AXI4-Lite-style SRAM responder with independent read/write FSMs and fixed latency.
// Define SRAM_RAND_DELAY_EN to add 0..7 cycles of LFSR-driven extra latency per transaction.
module sram_axil_responder #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 32'h80000000,
  parameter int unsigned        READ_LAT    = 1,
  parameter int unsigned        WRITE_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS) << 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

  rstate_t rstate;
  wstate_t wstate;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [7:0]        rcnt, wcnt;
  logic [7:0]        rlat_load, wlat_load;

  logic [ADDR_W-1:0] roff, woff;
  logic              rhit, whit;
  logic [IDX_W-1:0]  ridx, widx;
  logic              mem_we;

  // Offset compare covers both the below-base and beyond-top cases without overflow.
  assign roff = araddr_q - BASE_ADDR;
  assign woff = awaddr_q - BASE_ADDR;
  assign rhit = (araddr_q >= BASE_ADDR) && ({1'b0, roff} < SPAN);
  assign whit = (awaddr_q >= BASE_ADDR) && ({1'b0, woff} < SPAN);
  assign ridx = roff[IDX_W+1:2];
  assign widx = woff[IDX_W+1:2];

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign rlat_load = 8'(READ_LAT)  + {5'd0, lfsr[2:0]};
  assign wlat_load = 8'(WRITE_LAT) + {5'd0, lfsr[2:0]};
`else
  assign rlat_load = 8'(READ_LAT);
  assign wlat_load = 8'(WRITE_LAT);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rstate   <= R_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rcnt     <= '0;
      araddr_q <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (arvalid) begin
            araddr_q <= araddr;
            arready  <= 1'b0;
            rcnt     <= rlat_load;
            rstate   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rcnt == 8'd0) begin
            rdata  <= rhit ? mem[ridx] : '0;
            rresp  <= rhit ? RESP_OKAY : RESP_SLVERR;
            rvalid <= 1'b1;
            rstate <= R_RESP;
          end else begin
            rcnt <= rcnt - 8'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate   <= W_IDLE;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wcnt     <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            awaddr_q <= awaddr;
            awready  <= 1'b0;
          end
          if (wvalid && wready) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            wready  <= 1'b0;
          end
          // A lowered ready means that channel is already held; advance once both are.
          if ((!awready || awvalid) && (!wready || wvalid)) begin
            wcnt   <= wlat_load;
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wcnt == 8'd0) begin
            bresp  <= whit ? RESP_OKAY : RESP_SLVERR;
            bvalid <= 1'b1;
            wstate <= W_RESP;
          end else begin
            wcnt <= wcnt - 8'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  assign mem_we = rst && (wstate == W_WAIT) && (wcnt == 8'd0) && whit;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_axil_responder.sv
// Directed bench for sram_axil_responder: handshakes, latency, strobes, decode misses, reset abort.
module tb_sram_axil_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  sram_axil_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h80000000),
    .READ_LAT    (1),
    .WRITE_LAT   (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] d;
  logic [1:0]  resp;
  int          lat;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_b(output logic [1:0] r, output int l);
    l = 0;
    while (!bvalid && l < 50) begin
      tick;
      l++;
    end
    chk("b_timeout", {31'd0, bvalid}, 32'd1);
    r = bresp;
    bready = 1'b1;
    tick;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                           output logic [1:0] r, output int l);
    int  n;
    logic awf, wf;
    awaddr = a; wdata = dat; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      awf = awvalid && awready;
      wf  = wvalid && wready;
      tick;
      if (awf) awvalid = 1'b0;
      if (wf)  wvalid  = 1'b0;
      n++;
    end
    chk("aw_w_accept_timeout", {31'd0, awvalid | wvalid}, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(r, l);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] dat, output logic [1:0] r,
                          output int l);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick;
      n++;
    end
    tick;
    arvalid = 1'b0;
    l = 0;
    while (!rvalid && l < 50) begin
      tick;
      l++;
    end
    chk("r_timeout", {31'd0, rvalid}, 32'd1);
    dat = rdata;
    r   = rresp;
    rready = 1'b1;
    tick;
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    tick;
    tick;

    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready",  {31'd0, wready},  32'd1);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    rst = 1'b1;
    tick;

    // Basic write then read, with latency checks.
    axi_write(32'h80000000, 32'hDEADBEEF, 4'hF, resp, lat);
    chk("w0_bresp", {30'd0, resp}, 32'd0);
    chk("w0_blat",  lat,           32'd2);
    axi_read(32'h80000000, d, resp, lat);
    chk("r0_rdata", d,             32'hDEADBEEF);
    chk("r0_rresp", {30'd0, resp}, 32'd0);
    chk("r0_rlat",  lat,           32'd2);

    // Byte strobes.
    axi_write(32'h80000004, 32'h11223344, 4'hF, resp, lat);
    chk("w1_bresp", {30'd0, resp}, 32'd0);
    axi_write(32'h80000004, 32'hAABBCCDD, 4'b0101, resp, lat);
    chk("w2_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h80000004, d, resp, lat);
    chk("strb_rdata", d, 32'h11BB33DD);

    // Empty strobe: OKAY, word unchanged.
    axi_write(32'h80000004, 32'hFFFFFFFF, 4'h0, resp, lat);
    chk("strb0_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h80000004, d, resp, lat);
    chk("strb0_rdata", d, 32'h11BB33DD);

    // W arrives three cycles ahead of AW.
    awaddr = 32'h80000008; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    chk("wfirst_wready",  {31'd0, wready},  32'd0);
    chk("wfirst_awready", {31'd0, awready}, 32'd1);
    tick;
    tick;
    chk("wfirst_bvalid_early", {31'd0, bvalid}, 32'd0);
    awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    chk("wfirst_awready_drop", {31'd0, awready}, 32'd0);
    wait_b(resp, lat);
    chk("wfirst_blat",  lat,           32'd2);
    chk("wfirst_bresp", {30'd0, resp}, 32'd0);
    axi_read(32'h80000008, d, resp, lat);
    chk("wfirst_rdata", d, 32'hCAFEF00D);

    // Backpressure on R with a second request pending.
    araddr = 32'h80000000; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin
      tick;
      lat++;
    end
    chk("bp_rlat", lat, 32'd2);
    araddr = 32'h80000004; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  {31'd0, rvalid},  32'd1);
      chk("bp_rdata",   rdata,            32'hDEADBEEF);
      chk("bp_arready", {31'd0, arready}, 32'd0);
      tick;
    end
    rready = 1'b1;
    tick;
    rready = 1'b0;
    chk("bp_rvalid_drop",   {31'd0, rvalid},  32'd0);
    chk("bp_arready_back",  {31'd0, arready}, 32'd1);
    tick;
    arvalid = 1'b0;
    chk("bp_second_accept", {31'd0, arready}, 32'd0);
    lat = 0;
    while (!rvalid && lat < 50) begin
      tick;
      lat++;
    end
    chk("bp_second_rlat",  lat,   32'd2);
    chk("bp_second_rdata", rdata, 32'h11BB33DD);
    rready = 1'b1;
    tick;
    rready = 1'b0;

    // Decode boundaries.
    axi_write(32'h80003FFC, 32'h0BADF00D, 4'hF, resp, lat);
    chk("top_bresp", {30'd0, resp}, 32'd0);
    axi_write(32'h7FFFFFFC, 32'h12345678, 4'hF, resp, lat);
    chk("below_bresp", {30'd0, resp}, 32'd2);
    axi_write(32'h80004000, 32'h9ABCDEF0, 4'hF, resp, lat);
    chk("above_bresp", {30'd0, resp}, 32'd2);
    axi_read(32'h7FFFFFFC, d, resp, lat);
    chk("below_rresp", {30'd0, resp}, 32'd2);
    chk("below_rdata", d,             32'd0);
    axi_read(32'h80004000, d, resp, lat);
    chk("above_rresp", {30'd0, resp}, 32'd2);
    chk("above_rdata", d,             32'd0);
    axi_read(32'h80003FFC, d, resp, lat);
    chk("top_rdata", d,             32'h0BADF00D);
    chk("top_rresp", {30'd0, resp}, 32'd0);
    axi_read(32'h80000000, d, resp, lat);
    chk("word0_intact", d, 32'hDEADBEEF);

    // Reset while both channels are waiting.
    araddr = 32'h80000000; arvalid = 1'b1;
    awaddr = 32'h80000000; wdata = 32'h55555555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
      chk("abort_bvalid", {31'd0, bvalid}, 32'd0);
      tick;
    end
    chk("abort_arready", {31'd0, arready}, 32'd1);
    chk("abort_awready", {31'd0, awready}, 32'd1);
    chk("abort_wready",  {31'd0, wready},  32'd1);
    axi_read(32'h80000000, d, resp, lat);
    chk("abort_word_kept", d, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_axil_responder.md
Name: sram_axil_responder

Overview:
- Memory-side responder for the core's instruction and load/store fetch path.
- Answers AXI4-Lite-style valid/ready requests from an initiator such as the IFU or LSU.
- Backed by an internal word array, with fixed (or optionally pseudo-random) response latency.
- Replaces the zero-latency combinational memory so the core can move to a handshake bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; strobe width DATA_W/8)
DEPTH_WORDS, 4096, number of 32-bit words stored
BASE_ADDR, 32'h80000000, byte address of word 0
READ_LAT, 1, extra wait cycles between AR handshake and rvalid
WRITE_LAT, 1, extra wait cycles between last of AW/W capture and bvalid

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, synchronous, active-low (0 = reset, sampled on rising clk)
araddr  input  32  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response: 00 OKAY, 10 SLVERR
rvalid  output  1  read data valid
rready  input  1  read data ready
awaddr  input  32  write address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte enables; bit i enables byte i
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response: 00 OKAY, 10 SLVERR
bvalid  output  1  write response valid
bready  input  1  write response ready

Behaviour:
- Reset values:
  - arready = awready = wready = 1.
  - rvalid = bvalid = 0.
  - rdata = 0, rresp = 00, bresp = 00.
  - Array contents are not reset.
- Handshake: a transfer occurs on a rising edge where valid && ready. Once valid is high, outputs hold stable until the handshake completes.
- Address decode:
  - Hit if BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
  - Index = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
  - Miss: SLVERR, no array write, rdata = 0.
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready = 1. On AR handshake, latch araddr, drop arready, load counter with READ_LAT, go to R_WAIT.
  - R_WAIT: decrement counter each cycle. When counter == 0, sample the array into rdata/rresp and go to R_RESP.
  - rvalid rises exactly READ_LAT+1 cycles after the AR handshake edge.
  - R_RESP: rvalid = 1, rdata/rresp held. On R handshake, rvalid drops and go to R_IDLE; arready = 1 on the next cycle.
  - One outstanding read at a time.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: AW and W are captured independently, in either order or in the same cycle. Each ready drops after its own capture.
  - Once both are held, load counter with WRITE_LAT and go to W_WAIT.
  - W_WAIT: when counter == 0, commit the bytes selected by wstrb, set bresp, assert bvalid, go to W_RESP.
  - W_RESP: on B handshake, clear bvalid and return to W_IDLE with awready = wready = 1.
  - wstrb = 0 is legal: OKAY response, array unchanged.
- Read and write channels run concurrently.
- If a write commit and a read sample fall on the same edge at the same word, the read returns the pre-write data.
- rst low at any time, mid-transaction included:
  - Both FSMs return to idle and all outputs take their reset values on the next edge.
  - A pending write is discarded and not committed.
- Latency counters are 8 bits wide; READ_LAT and WRITE_LAT must be at most 255.

Optional Feature:
- Macro: SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded with 8'hA5 on reset and advances every cycle.
  - At each AR handshake (or final AW/W capture), the counter loads READ_LAT (or WRITE_LAT) + lfsr[2:0]. Extra delay is 0..7 cycles.
  - The sequence is deterministic from reset.
- Undefined: the LFSR is absent and latency is exactly the fixed parameter value.

Test Plan:
- Write 0x80000000 <= 0xDEADBEEF, wstrb 4'hF, then read it back -> bresp 00; rvalid exactly 2 cycles after AR handshake (READ_LAT=1); rdata 0xDEADBEEF, rresp 00.
- Write 0x80000004 <= 0x11223344 (strb F), then 0xAABBCCDD with strb 4'b0101, then read -> rdata 0x11BB33DD.
- Assert wvalid 3 cycles before awvalid -> wready drops after W capture, bvalid only WRITE_LAT+1 cycles after AW capture; read-back matches.
- Hold rready = 0 for 5 cycles after rvalid -> rvalid/rdata stable, arready 0, a second arvalid is not accepted until after the R handshake.
- Read and write 0x7FFFFFFC and 0x80004000 -> rresp/bresp 10, rdata 0, no in-range word altered.
- Drive rst = 0 while in R_WAIT and W_WAIT -> rvalid/bvalid never rise; arready/awready/wready = 1 after release; target word retains its old value.
